dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_store.sv | 59 +++++
 rtl/dmem_responder.sv | 137 +++++++++++++
 tb/tb_dmem_responder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: block/word geometry,
// write-size encoding and the block-transfer state machine encoding.
package dmem_pkg;

  localparam int BLOCK_BITS = 256;
  localparam int WORD_BITS  = 32;

  // data_write_size_2DM: 1..3 write that many bytes, 0 writes a full word
  localparam logic [1:0] SZ_4B = 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_RD = 2'd1,
    ST_BUSY_WR = 2'd2
  } blk_state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    return (size == SZ_4B) ? 3'd4 : {1'b0, size};
  endfunction

endpackage

// File: rtl/dmem_store.sv
// Block-organised storage with a combinational word port (byte-granular big-endian
// writes) and a full-block port; a block write overrides a same-edge word write.
module dmem_store import dmem_pkg::*; #(
  parameter int DEPTH_BLOCKS = 64,
  parameter int IDX_W        = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [IDX_W-1:0]      i_word_idx,
  input  logic [2:0]            i_word_sel,
  input  logic [1:0]            i_word_off,
  input  logic                  i_word_we,
  input  logic [WORD_BITS-1:0]  i_word_wdata,
  input  logic [1:0]            i_word_size,
  output logic [WORD_BITS-1:0]  o_word_rdata,
  input  logic [IDX_W-1:0]      i_blk_idx,
  input  logic                  i_blk_we,
  input  logic [BLOCK_BITS-1:0] i_blk_wdata,
  output logic [BLOCK_BITS-1:0] o_blk_rdata
);

  logic [BLOCK_BITS-1:0] r_mem [DEPTH_BLOCKS];

  logic [7:0]           w_word_lsb;
  logic [5:0]           w_lead_sh;
  logic [4:0]           w_off_sh;
  logic [WORD_BITS-1:0] w_src;
  logic [WORD_BITS-1:0] w_mask;
  logic [WORD_BITS-1:0] w_word_new;

  // word 0 sits in the top 32 bits of the block, so its LSB position is (7-sel)*32
  assign w_word_lsb   = {~i_word_sel, 5'b0};
  assign o_word_rdata = r_mem[i_word_idx][w_word_lsb +: WORD_BITS];
  assign o_blk_rdata  = r_mem[i_blk_idx];

  // Left-justify the n payload bytes, then slide them to the byte offset;
  // anything shifted past offset 3 falls off the end of the word.
  assign w_lead_sh  = {3'd4 - size_bytes(i_word_size), 3'b0};
  assign w_off_sh   = {i_word_off, 3'b0};
  assign w_src      = (i_word_wdata << w_lead_sh) >> w_off_sh;
  assign w_mask     = ({WORD_BITS{1'b1}} << w_lead_sh) >> w_off_sh;
  assign w_word_new = (o_word_rdata & ~w_mask) | (w_src & w_mask);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH_BLOCKS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_word_we) begin
        r_mem[i_word_idx][w_word_lsb +: WORD_BITS] <= w_word_new;
      end
      if (i_blk_we) begin
        r_mem[i_blk_idx] <= i_blk_wdata;
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: zero-latency word port plus a fixed-latency block
// read/write engine with one-cycle completion pulses and abort on request drop.
module dmem_responder import dmem_pkg::*; #(
  parameter int DEPTH_BLOCKS = 64,
  parameter int LATENCY      = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           data_address_2DM,
  input  logic                  MemRead_2DM,
  input  logic                  MemWrite_2DM,
  input  logic [31:0]           data_write_2DM,
  input  logic [1:0]            data_write_size_2DM,
  output logic [31:0]           data_read_fDM,
  input  logic                  dBlkRead,
  input  logic                  dBlkWrite,
  input  logic [BLOCK_BITS-1:0] block_write_2DM,
  output logic [BLOCK_BITS-1:0] block_read_fDM,
  output logic                  block_read_fDM_valid,
  output logic                  block_write_fDM_valid
);

  localparam int         IDX_W    = (DEPTH_BLOCKS > 1) ? $clog2(DEPTH_BLOCKS) : 1;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  blk_state_t            r_state, w_next_state;
  logic [3:0]            r_cnt, w_next_cnt;
  logic [IDX_W-1:0]      r_blk_idx;
  logic [BLOCK_BITS-1:0] r_blk_wdata;
  logic [BLOCK_BITS-1:0] r_block_read;

  logic [IDX_W-1:0]      w_addr_idx;
  logic [IDX_W-1:0]      w_blk_idx;
  logic [BLOCK_BITS-1:0] w_blk_wdata;
  logic [BLOCK_BITS-1:0] w_blk_rdata;
  logic                  w_accept;
  logic                  w_complete;
  logic                  w_is_rd;
  logic                  w_req;
  logic                  w_unused;

  assign w_addr_idx = data_address_2DM[5 +: IDX_W];
  // Word reads are not gated by MemRead; upper address bits wrap by design.
  assign w_unused   = ^{MemRead_2DM, data_address_2DM[31:5+IDX_W]};

  // With LATENCY==1 completion coincides with acceptance, so use the live inputs.
  assign w_blk_idx   = (r_state == ST_IDLE) ? w_addr_idx      : r_blk_idx;
  assign w_blk_wdata = (r_state == ST_IDLE) ? block_write_2DM : r_blk_wdata;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_blk_idx   <= w_addr_idx;
      r_blk_wdata <= block_write_2DM;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_block_read <= '0;
    end else if (w_complete && w_is_rd) begin
      r_block_read <= w_blk_rdata;
    end
  end

  // cnt counts down to 1 on the completion edge; cnt==0 while busy is the pulse cycle.
  always_comb begin
    w_next_state          = r_state;
    w_next_cnt            = r_cnt;
    w_accept              = 1'b0;
    w_complete            = 1'b0;
    w_is_rd               = (r_state == ST_BUSY_RD);
    w_req                 = 1'b0;
    block_read_fDM_valid  = 1'b0;
    block_write_fDM_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_is_rd = dBlkRead;
        if (dBlkRead || dBlkWrite) begin
          w_accept     = 1'b1;
          w_next_state = dBlkRead ? ST_BUSY_RD : ST_BUSY_WR;
          w_next_cnt   = CNT_LOAD;
          w_complete   = (LATENCY == 1);
        end
      end
      ST_BUSY_RD, ST_BUSY_WR: begin
        w_req = w_is_rd ? dBlkRead : dBlkWrite;
        if (r_cnt == 4'd0) begin
          w_next_state          = ST_IDLE;
          block_read_fDM_valid  = w_is_rd;
          block_write_fDM_valid = !w_is_rd;
        end else if (!w_req) begin
          w_next_state = ST_IDLE;
          w_next_cnt   = 4'd0;
        end else begin
          w_next_cnt = r_cnt - 4'd1;
          w_complete = (r_cnt == 4'd1);
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = 4'd0;
      end
    endcase
  end

  assign block_read_fDM = r_block_read;

  dmem_store #(
    .DEPTH_BLOCKS (DEPTH_BLOCKS),
    .IDX_W        (IDX_W)
  ) u_store (
    .i_clk        (CLK),
    .i_rst        (RESET),
    .i_word_idx   (w_addr_idx),
    .i_word_sel   (data_address_2DM[4:2]),
    .i_word_off   (data_address_2DM[1:0]),
    .i_word_we    (MemWrite_2DM),
    .i_word_wdata (data_write_2DM),
    .i_word_size  (data_write_size_2DM),
    .o_word_rdata (data_read_fDM),
    .i_blk_idx    (w_blk_idx),
    .i_blk_we     (w_complete && !w_is_rd),
    .i_blk_wdata  (w_blk_wdata),
    .o_blk_rdata  (w_blk_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-array reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 4;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  data_address_2DM;
  logic         MemRead_2DM, MemWrite_2DM;
  logic [31:0]  data_write_2DM;
  logic [1:0]   data_write_size_2DM;
  logic [31:0]  data_read_fDM;
  logic         dBlkRead, dBlkWrite;
  logic [255:0] block_write_2DM, block_read_fDM;
  logic         block_read_fDM_valid, block_write_fDM_valid;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_responder #(.DEPTH_BLOCKS(DEPTH), .LATENCY(LAT)) dut (
    .CLK                   (CLK),
    .RESET                 (RESET),
    .data_address_2DM      (data_address_2DM),
    .MemRead_2DM           (MemRead_2DM),
    .MemWrite_2DM          (MemWrite_2DM),
    .data_write_2DM        (data_write_2DM),
    .data_write_size_2DM   (data_write_size_2DM),
    .data_read_fDM         (data_read_fDM),
    .dBlkRead              (dBlkRead),
    .dBlkWrite             (dBlkWrite),
    .block_write_2DM       (block_write_2DM),
    .block_read_fDM        (block_read_fDM),
    .block_read_fDM_valid  (block_read_fDM_valid),
    .block_write_fDM_valid (block_write_fDM_valid)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: flat byte array, block b occupies bytes b*32..b*32+31, byte 0 = MSB.
  logic [7:0]   m_mem [DEPTH*32];
  bit           m_busy = 1'b0;
  bit           m_rd   = 1'b0;
  bit           m_done;
  int           m_age  = 0;
  logic [31:0]  m_addr;
  logic [255:0] m_wdata;
  logic [255:0] m_blk;
  bit           cmp_en = 1'b0;

  function automatic int blk_base(input logic [31:0] a);
    return int'((a >> 5) % DEPTH) * 32;
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] a);
    int b;
    b = blk_base(a) + int'(a[4:2]) * 4;
    return {m_mem[b], m_mem[b+1], m_mem[b+2], m_mem[b+3]};
  endfunction

  function automatic logic [255:0] m_block(input logic [31:0] a);
    logic [255:0] r;
    int b;
    b = blk_base(a);
    for (int i = 0; i < 32; i++) r[255-8*i -: 8] = m_mem[b+i];
    return r;
  endfunction

  task automatic m_put_block(input logic [31:0] a, input logic [255:0] d);
    int b;
    b = blk_base(a);
    for (int i = 0; i < 32; i++) m_mem[b+i] = d[255-8*i -: 8];
  endtask

  task automatic m_word_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    int n, b, off;
    n   = (sz == 2'd0) ? 4 : int'(sz);
    b   = blk_base(a) + int'(a[4:2]) * 4;
    off = int'(a[1:0]);
    for (int j = 0; j < n; j++) begin
      if (off + j < 4) m_mem[b+off+j] = d[8*(n-1-j) +: 8];
    end
  endtask

  // m_age = number of the current cycle counted from the acceptance cycle (0).
  initial forever begin
    @(posedge CLK);
    if (RESET) begin
      foreach (m_mem[i]) m_mem[i] = 8'h00;
      m_busy = 1'b0;
      m_age  = 0;
      m_blk  = '0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (m_age == LAT) m_busy = 1'b0;
        else if (!(m_rd ? dBlkRead : dBlkWrite)) m_busy = 1'b0;
        else begin
          m_age++;
          m_done = (m_age == LAT);
        end
      end else if (dBlkRead || dBlkWrite) begin
        m_busy  = 1'b1;
        m_rd    = dBlkRead;
        m_addr  = data_address_2DM;
        m_wdata = block_write_2DM;
        m_age   = 1;
        m_done  = (LAT == 1);
      end
      if (m_done && m_rd) m_blk = m_block(m_addr);
      if (MemWrite_2DM) m_word_write(data_address_2DM, data_write_2DM, data_write_size_2DM);
      if (m_done && !m_rd) m_put_block(m_addr, m_wdata);
    end
  end

  initial forever begin
    @(negedge CLK);
    if (cmp_en) begin
      chk("model_rd_valid", 256'(block_read_fDM_valid), 256'(m_busy && m_rd && m_age == LAT));
      chk("model_wr_valid", 256'(block_write_fDM_valid), 256'(m_busy && !m_rd && m_age == LAT));
      chk("model_blk_data", block_read_fDM, m_blk);
      if (MemRead_2DM) chk("model_word_rd", 256'(data_read_fDM), 256'(m_word(data_address_2DM)));
    end
  end

  task automatic word_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    data_address_2DM    = a;
    data_write_2DM      = d;
    data_write_size_2DM = sz;
    MemWrite_2DM        = 1'b1;
    @(posedge CLK); #1;
    MemWrite_2DM = 1'b0;
  endtask

  task automatic word_read(input string name, input logic [31:0] a, input logic [31:0] exp);
    data_address_2DM = a;
    MemRead_2DM      = 1'b1;
    #1;
    chk(name, 256'(data_read_fDM), 256'(exp));
    MemRead_2DM = 1'b0;
  endtask

  // Runs one block request for a fixed 12-cycle window; reports first pulse cycle and pulse counts.
  task automatic blk(input bit rd, input bit wr, input logic [31:0] addr, input logic [255:0] data,
                     input int drop_at, input int ww_at, input logic [31:0] ww_addr,
                     input logic [31:0] ww_data, output int vr, output int vw,
                     output int nr, output int nw);
    vr = -1; vw = -1; nr = 0; nw = 0;
    MemRead_2DM      = 1'b0;
    data_address_2DM = addr;
    block_write_2DM  = data;
    dBlkRead         = rd;
    dBlkWrite        = wr;
    for (int c = 1; c <= 12; c++) begin
      @(posedge CLK); #1;
      MemWrite_2DM = 1'b0;
      if (c == drop_at) begin
        dBlkRead  = 1'b0;
        dBlkWrite = 1'b0;
      end
      if (c == ww_at) begin
        data_address_2DM    = ww_addr;
        data_write_2DM      = ww_data;
        data_write_size_2DM = 2'd0;
        MemWrite_2DM        = 1'b1;
      end
      if (block_read_fDM_valid) begin
        nr++;
        if (vr < 0) vr = c;
        dBlkRead = 1'b0;
      end
      if (block_write_fDM_valid) begin
        nw++;
        if (vw < 0) vw = c;
        dBlkWrite = 1'b0;
      end
    end
    dBlkRead     = 1'b0;
    dBlkWrite    = 1'b0;
    MemWrite_2DM = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  logic [255:0] pat, pat2;
  int vr, vw, nr, nw;

  initial begin
    RESET = 1'b1;
    data_address_2DM = '0; MemRead_2DM = 1'b0; MemWrite_2DM = 1'b0;
    data_write_2DM = '0; data_write_size_2DM = '0;
    dBlkRead = 1'b0; dBlkWrite = 1'b0; block_write_2DM = '0;
    for (int k = 0; k < 8; k++) begin
      pat[255-32*k -: 32]  = 32'(k);
      pat2[255-32*k -: 32] = 32'hC0DE0000 + 32'(k);
    end
    repeat (2) @(posedge CLK);
    #1;
    RESET  = 1'b0;
    cmp_en = 1'b1;

    chk("reset_rd_valid", 256'(block_read_fDM_valid), 256'(0));
    chk("reset_wr_valid", 256'(block_write_fDM_valid), 256'(0));
    chk("reset_blk_data", block_read_fDM, '0);
    word_read("reset_word", 32'h100, 32'h0);

    word_write(32'h100, 32'hAABBCCDD, 2'd0);
    word_read("word_full", 32'h100, 32'hAABBCCDD);
    word_write(32'h101, 32'h000000EE, 2'd1);
    word_read("word_size1", 32'h100, 32'hAAEECCDD);
    word_write(32'h102, 32'h00112233, 2'd3);
    word_read("word_size3_drop", 32'h100, 32'hAAEE1122);
    word_write(32'h107, 32'h00005566, 2'd2);
    word_read("word_size2_drop", 32'h104, 32'h00000055);

    blk(1, 0, 32'h100, '0, 0, 0, 0, 0, vr, vw, nr, nw);
    chk("blkrd_cycle", 256'(vr), 256'(4));
    chk("blkrd_pulses", 256'(nr), 256'(1));
    chk("blkrd_no_wr", 256'(nw), 256'(0));
    chk("blkrd_word0", 256'(block_read_fDM[255:224]), 256'(32'hAAEE1122));
    chk("blkrd_word1", 256'(block_read_fDM[223:192]), 256'(32'h00000055));

    blk(0, 1, 32'h2000, pat, 0, 0, 0, 0, vr, vw, nr, nw);
    chk("blkwr_cycle", 256'(vw), 256'(4));
    chk("blkwr_pulses", 256'(nw), 256'(1));
    for (int k = 0; k < 8; k++) word_read("blkwr_word", 32'h2000 + 32'(4*k), 32'(k));
    word_read("wrap_word0", 32'h0000, 32'd0);
    word_read("wrap_word7", 32'h001C, 32'd7);
    blk(1, 0, 32'h0000, '0, 0, 0, 0, 0, vr, vw, nr, nw);
    chk("wrap_blkrd", block_read_fDM, pat);

    blk(1, 1, 32'h140, pat2, 0, 0, 0, 0, vr, vw, nr, nw);
    chk("tie_rd_first", 256'(vr), 256'(4));
    chk("tie_wr_after", 256'(vw), 256'(9));
    chk("tie_rd_pulses", 256'(nr), 256'(1));
    chk("tie_wr_pulses", 256'(nw), 256'(1));
    word_read("tie_wr_data", 32'h140, 32'hC0DE0000);

    blk(0, 1, 32'h180, pat2, 2, 0, 0, 0, vr, vw, nr, nw);
    chk("abort_wr_pulses", 256'(nw), 256'(0));
    word_read("abort_wr_nocommit", 32'h180, 32'h0);
    blk(1, 0, 32'h2000, '0, 2, 0, 0, 0, vr, vw, nr, nw);
    chk("abort_rd_pulses", 256'(nr), 256'(0));
    chk("abort_rd_hold", block_read_fDM, '0);

    blk(0, 1, 32'h1C0, pat, 0, 3, 32'h1C4, 32'hDEADBEEF, vr, vw, nr, nw);
    chk("override_cycle", 256'(vw), 256'(4));
    word_read("override_word", 32'h1C4, 32'd1);

    blk(1, 0, 32'h2000, '0, 0, 0, 0, 0, vr, vw, nr, nw);
    chk("pre_reset_blk", block_read_fDM, pat);

    data_address_2DM = 32'h300;
    block_write_2DM  = pat2;
    dBlkWrite        = 1'b1;
    repeat (2) begin @(posedge CLK); #1; end
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET     = 1'b0;
    dBlkWrite = 1'b0;
    chk("rst_blk_clear", block_read_fDM, '0);
    nw = 0;
    repeat (6) begin
      @(posedge CLK); #1;
      if (block_write_fDM_valid) nw++;
    end
    chk("rst_no_wr_pulse", 256'(nw), 256'(0));
    blk(1, 0, 32'h300, '0, 0, 0, 0, 0, vr, vw, nr, nw);
    chk("rst_blkrd_cycle", 256'(vr), 256'(4));
    chk("rst_blkrd_zero", block_read_fDM, '0);
    word_read("rst_storage_zero", 32'h100, 32'h0);

    @(posedge CLK); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
